// File: rtl/trigger_capture_ctrl.sv
// Trigger sequencing controller: N-frame confirm, beat-counted capture window, hold-off.
// Optional TRIG_TIMESTAMP_EN adds a free-running cycle counter latched on capture start.
module trigger_capture_ctrl #(
  parameter int CNT_W  = 16,
  parameter int CONF_W = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              arm,
  input  logic              abort,
  input  logic              t_valid,
  input  logic              trigger,
  input  logic              frame_done,
  input  logic [CONF_W-1:0] confirm_frames,
  input  logic [CNT_W-1:0]  capture_len,
  input  logic [CNT_W-1:0]  holdoff_len,
  output logic              capture_en,
  output logic              capture_done,
  output logic              busy,
  output logic [2:0]        state,
  output logic [CONF_W-1:0] hit_frames
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [31:0]       timestamp
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CONFIRM = 3'd2,
    CAPTURE = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t              cur, nxt;
  logic                hit, hit_d;
  logic [CONF_W-1:0]   hits_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [CNT_W-1:0]    win_len, win_len_d;
  logic                done_d;
  logic                frame_hit;
  logic [CONF_W:0]     hits_inc;
  logic [CONF_W-1:0]   eff_confirm;
  logic [CNT_W-1:0]    eff_capture, eff_holdoff;

  assign eff_confirm = (confirm_frames == '0) ? CONF_W'(1) : confirm_frames;
  assign eff_capture = (capture_len == '0) ? CNT_W'(1) : capture_len;
  assign eff_holdoff = (holdoff_len == '0) ? CNT_W'(1) : holdoff_len;
  // A hit landing on the frame_done cycle still belongs to the closing frame.
  assign frame_hit   = hit | (trigger & t_valid);
  assign hits_inc    = {1'b0, hit_frames} + (CONF_W + 1)'(1);
  assign state       = cur;

  always_comb begin
    nxt       = cur;
    hit_d     = 1'b0;
    hits_d    = hit_frames;
    cnt_d     = '0;
    win_len_d = win_len;
    done_d    = 1'b0;
    case (cur)
      IDLE: begin
        hits_d = '0;
        if (arm) nxt = ARMED;
      end
      ARMED, CONFIRM: begin
        if (!arm) begin
          nxt    = IDLE;
          hits_d = '0;
        end else if (frame_done) begin
          if (frame_hit) begin
            if (hits_inc >= {1'b0, eff_confirm}) begin
              nxt       = CAPTURE;
              hits_d    = '0;
              win_len_d = eff_capture;
            end else begin
              nxt    = CONFIRM;
              hits_d = (hit_frames == '1) ? hit_frames : hits_inc[CONF_W-1:0];
            end
          end else begin
            nxt    = ARMED;
            hits_d = '0;
          end
        end else begin
          hit_d = frame_hit;
        end
      end
      CAPTURE: begin
        cnt_d = cnt;
        if (t_valid) begin
          if (cnt == win_len - CNT_W'(1)) begin
            // win_len is reused for the hold-off length, sampled here on entry.
            nxt       = HOLDOFF;
            cnt_d     = '0;
            win_len_d = eff_holdoff;
            done_d    = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      HOLDOFF: begin
        if (cnt == win_len - CNT_W'(1)) nxt = arm ? ARMED : IDLE;
        else cnt_d = cnt + CNT_W'(1);
      end
      default: begin
        nxt    = IDLE;
        hits_d = '0;
      end
    endcase
    if (abort) begin
      nxt       = IDLE;
      hit_d     = 1'b0;
      hits_d    = '0;
      cnt_d     = '0;
      win_len_d = '0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      cur          <= IDLE;
      hit          <= 1'b0;
      hit_frames   <= '0;
      cnt          <= '0;
      win_len      <= '0;
      capture_done <= 1'b0;
      capture_en   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cur          <= nxt;
      hit          <= hit_d;
      hit_frames   <= hits_d;
      cnt          <= cnt_d;
      win_len      <= win_len_d;
      capture_done <= done_d;
      capture_en   <= (nxt == CAPTURE);
      busy         <= (nxt == CONFIRM) || (nxt == CAPTURE) || (nxt == HOLDOFF);
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] cyc;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      cyc       <= '0;
      timestamp <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (nxt == CAPTURE && cur != CAPTURE) timestamp <= cyc;
    end
  end
`endif

endmodule

// File: doc/trigger_capture_ctrl.md
# trigger_capture_ctrl

Sequencing controller for the acoustic trigger path. It takes the per-sample threshold trigger and the end-of-frame strobe from the FFT trigger detector and requires a hit in N consecutive FFT frames before declaring a valid ping. It then opens a capture window of a programmable number of sample beats for the downstream hydrophone sample buffers, and finally enforces a hold-off before re-arming. It sits between the trigger detector and the capture/DMA logic, under software control via `arm`/`abort`.

## Interface
- `CNT_W`, 16, width of capture and hold-off counters and of their length inputs
- `CONF_W`, 4, width of confirm-frame count input and `hit_frames`
- `clk`  in  1  single clock for all logic
- `reset_b`  in  1  synchronous, active-low reset
- `arm`  in  1  level; enables triggering while high
- `abort`  in  1  level; forces IDLE; overrides everything except reset
- `t_valid`  in  1  sample-beat qualifier from the AXI stream
- `trigger`  in  1  detector trigger; used only when `t_valid`=1
- `frame_done`  in  1  one-cycle end-of-FFT-frame strobe
- `confirm_frames`  in  CONF_W  consecutive hit frames required; 0 is treated as 1
- `capture_len`  in  CNT_W  capture window length in `t_valid` beats; 0 is treated as 1
- `holdoff_len`  in  CNT_W  hold-off length in clk cycles; 0 is treated as 1
- `capture_en`  out  1  high for the whole CAPTURE state
- `capture_done`  out  1  one-cycle pulse at the end of the window
- `busy`  out  1  high in CONFIRM, CAPTURE and HOLDOFF
- `state`  out  3  current FSM encoding
- `hit_frames`  out  CONF_W  running count of consecutive hit frames
- `timestamp`  out  32  cycle count at confirm; exists only with `TRIG_TIMESTAMP_EN`

## Operation
- All outputs are registered. Reset value of every output and internal counter is 0, and the state resets to IDLE.
- State encoding: IDLE=0, ARMED=1, CONFIRM=2, CAPTURE=3, HOLDOFF=4. Codes 5–7 are illegal and recover to IDLE on the next cycle.
- `hit` is a per-frame sticky flag. It is set by `trigger && t_valid` and cleared on every `frame_done`. The frame evaluation treats a hit in the same cycle as `frame_done` as part of the current frame.
- IDLE: go to ARMED when `arm`=1; `hit` and `hit_frames` are held at 0.
- ARMED/CONFIRM on `frame_done`:
  - Frame hit and `hit_frames`+1 ≥ eff_confirm: go to CAPTURE and clear `hit_frames`.
  - Frame hit otherwise: increment `hit_frames` and go to CONFIRM.
  - Frame missed: clear `hit_frames` and go to ARMED.
  - `hit_frames` saturates at its maximum value.
- ARMED/CONFIRM with `arm`=0: go to IDLE and clear the counters. A window that has already started (CAPTURE or later) is unaffected by `arm` dropping.
- CAPTURE: the beat counter increments on each `t_valid`. On the beat where count = eff_capture−1:
  - go to HOLDOFF,
  - `capture_en` falls,
  - `capture_done`=1 for exactly one cycle.
- HOLDOFF: count clk cycles. After eff_holdoff cycles, go to ARMED if `arm`=1, otherwise IDLE. Triggers and frames are ignored during HOLDOFF.
- `abort`=1 in any state: next state is IDLE, all counters clear, `capture_en`=0, and no `capture_done` pulse is issued.
- Length inputs are sampled on state entry (CAPTURE entry for `capture_len`, HOLDOFF entry for `holdoff_len`). Changes mid-window have no effect.

## Timing
- From the confirming `frame_done` at cycle T: `state`=CAPTURE and `capture_en`=1 at T+1. The first counted beat can be at T+1.
- With eff_capture=L, `capture_en` stays high until the L-th beat with `t_valid`. `capture_done` is high in the cycle after that beat.
- HOLDOFF lasts exactly eff_holdoff cycles. The earliest ARMED is at (HOLDOFF entry)+eff_holdoff.
- `abort` or `reset_b`=0 sampled at edge E: outputs are at reset/IDLE values after E.
- Minimum trigger-to-capture latency is 1 cycle when confirm=1.

## Configuration
- `TRIG_TIMESTAMP_EN` defined:
  - A free-running 32-bit cycle counter (wraps, reset to 0) is instantiated.
  - Its value is latched into `timestamp` on the cycle the FSM enters CAPTURE and held until the next confirm.
  - `timestamp` resets to 0.
- `TRIG_TIMESTAMP_EN` undefined: neither the counter nor the `timestamp` port exists.

## Test plan
- Reset then arm, confirm=1, capture_len=4, holdoff_len=3, trigger+t_valid on the `frame_done` cycle → CAPTURE next cycle. `capture_en` is high for 4 `t_valid` beats, then a single `capture_done`, 3 cycles of HOLDOFF, then ARMED.
- confirm=3, frames hit/hit/miss/hit/hit/hit → `hit_frames` goes 1, 2, 0, 1, 2, then CAPTURE after the 6th `frame_done`.
- capture_len=0 and holdoff_len=0 → a 1-beat window and 1-cycle hold-off. With `t_valid` gapped, `capture_en` holds until the beat arrives.
- `abort` mid-CAPTURE (beat 2 of 8) → IDLE next cycle, `capture_en`=0, no `capture_done`. Same check with `reset_b`=0 in HOLDOFF → all outputs 0.
- `trigger`=1 with `t_valid`=0 across a frame → no hit counted. Drop `arm` in CONFIRM → IDLE and `hit_frames`=0. Drop `arm` in CAPTURE → window completes, then IDLE after hold-off.
- With `TRIG_TIMESTAMP_EN`: confirm at cycle 100 after reset → `timestamp`=100 (counter value at CAPTURE entry), held through the next window until the next confirm.
